// File: rtl/lpddr_burst_sequencer.sv
// Burst-slot ring sequencer that turns single-cycle write/read requests into LPDDR port commands.
// Optional sticky overrun/underrun flags are enabled by defining LPDDR_SEQ_ERR_EN.
module lpddr_burst_sequencer #(
  parameter int ADDR_W     = 30,
  parameter int BL         = 32,
  parameter int WORD_BYTES = 4,
  parameter int BASE_ADDR  = 32,
  parameter int NSLOT      = 1024
) (
  input  logic                     clkA_addr,
  input  logic                     addr_rstA_wr,
  input  logic                     soft_clr,
  input  logic                     wr_req,
  input  logic                     rd_req,
  input  logic                     cmd_full_wr,
  input  logic                     cmd_full_rd,
  output logic                     cmd_en_wr,
  output logic                     cmd_en_rd,
  output logic [ADDR_W-1:0]        cmd_addr_wr,
  output logic [ADDR_W-1:0]        cmd_addr_rd,
  output logic [5:0]               cmd_bl,
  output logic [$clog2(NSLOT):0]   level,
  output logic                     buf_full,
  output logic                     buf_empty,
  output logic                     busy,
  output logic                     ovr_err,
  output logic                     udr_err
);

  localparam int SW = $clog2(NSLOT);
  localparam int LW = SW + 1;
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BSTEP    = ADDR_W'(BL * WORD_BYTES);
  localparam logic [LW-1:0]     FULL_LVL = LW'(NSLOT);

  typedef enum logic [1:0] {IDLE, ISSUE_WR, ISSUE_RD, UPDATE} state_t;

  state_t        state;
  logic [1:0]    rst_sync;
  logic          rst_int;
  logic          wr_pend;
  logic          rd_pend;
  logic          cur_wr;
  logic          prio_rd;
  logic [SW-1:0] slot_wr;
  logic [SW-1:0] slot_rd;
  logic          in_upd_wr;
  logic          in_upd_rd;
  logic          wr_ok;
  logic          rd_ok;

  // Asynchronous assert, release aligned to clkA_addr.
  always_ff @(posedge clkA_addr or posedge addr_rstA_wr) begin
    if (addr_rstA_wr) rst_sync <= '1;
    else              rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  assign in_upd_wr = (state == UPDATE) && cur_wr;
  assign in_upd_rd = (state == UPDATE) && !cur_wr;

  // A burst sitting in UPDATE is counted so level can never leave 0..NSLOT.
  assign wr_ok = wr_req && !wr_pend && ((level + LW'(in_upd_wr)) < FULL_LVL);
  assign rd_ok = rd_req && !rd_pend && (level > LW'(in_upd_rd));

  // Strobe is qualified by cmd_full in the same cycle so the FIFO never sees a push while full.
  assign cmd_en_wr = (state == ISSUE_WR) && !cmd_full_wr;
  assign cmd_en_rd = (state == ISSUE_RD) && !cmd_full_rd;

  assign cmd_bl    = 6'(BL - 1);
  assign buf_full  = (level == FULL_LVL);
  assign buf_empty = (level == '0);
  assign busy      = (state != IDLE) || wr_pend || rd_pend;

  always_ff @(posedge clkA_addr or posedge rst_int) begin
    if (rst_int) begin
      state       <= IDLE;
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      cur_wr      <= 1'b0;
      prio_rd     <= 1'b0;
      slot_wr     <= '0;
      slot_rd     <= '0;
      level       <= '0;
      cmd_addr_wr <= BASE_A;
      cmd_addr_rd <= BASE_A;
    end else if (soft_clr) begin
      state       <= IDLE;
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      cur_wr      <= 1'b0;
      prio_rd     <= 1'b0;
      slot_wr     <= '0;
      slot_rd     <= '0;
      level       <= '0;
      cmd_addr_wr <= BASE_A;
      cmd_addr_rd <= BASE_A;
    end else begin
      wr_pend <= (wr_pend && !cmd_en_wr) || wr_ok;
      rd_pend <= (rd_pend && !cmd_en_rd) || rd_ok;
      case (state)
        IDLE: begin
          // Priority only rotates when both directions contend.
          if (wr_pend && rd_pend) begin
            state   <= prio_rd ? ISSUE_RD : ISSUE_WR;
            prio_rd <= !prio_rd;
          end else if (wr_pend) begin
            state <= ISSUE_WR;
          end else if (rd_pend) begin
            state <= ISSUE_RD;
          end
        end
        ISSUE_WR: begin
          if (!cmd_full_wr) begin
            state  <= UPDATE;
            cur_wr <= 1'b1;
          end
        end
        ISSUE_RD: begin
          if (!cmd_full_rd) begin
            state  <= UPDATE;
            cur_wr <= 1'b0;
          end
        end
        UPDATE: begin
          state <= IDLE;
          if (cur_wr) begin
            slot_wr     <= slot_wr + 1'b1;
            level       <= level + 1'b1;
            cmd_addr_wr <= (slot_wr == '1) ? BASE_A : cmd_addr_wr + BSTEP;
          end else begin
            slot_rd     <= slot_rd + 1'b1;
            level       <= level - 1'b1;
            cmd_addr_rd <= (slot_rd == '1) ? BASE_A : cmd_addr_rd + BSTEP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LPDDR_SEQ_ERR_EN
  always_ff @(posedge clkA_addr or posedge rst_int) begin
    if (rst_int) begin
      ovr_err <= 1'b0;
      udr_err <= 1'b0;
    end else if (soft_clr) begin
      ovr_err <= 1'b0;
      udr_err <= 1'b0;
    end else begin
      if (wr_req && !wr_ok) ovr_err <= 1'b1;
      if (rd_req && !rd_ok) udr_err <= 1'b1;
    end
  end
`else
  assign ovr_err = 1'b0;
  assign udr_err = 1'b0;
`endif

endmodule

// File: tb/tb_lpddr_burst_sequencer.sv
// Directed bench: default instance (NSLOT=1024) and a small ring instance (NSLOT=4).
module tb_lpddr_burst_sequencer;

`ifdef LPDDR_SEQ_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;

  logic        a_clr, a_wr_req, a_rd_req, a_full_wr, a_full_rd;
  logic        a_en_wr, a_en_rd, a_buf_full, a_buf_empty, a_busy, a_ovr, a_udr;
  logic [29:0] a_addr_wr, a_addr_rd;
  logic [5:0]  a_cmd_bl;
  logic [10:0] a_level;

  logic        b_clr, b_wr_req, b_rd_req, b_full_wr, b_full_rd;
  logic        b_en_wr, b_en_rd, b_buf_full, b_buf_empty, b_busy, b_ovr, b_udr;
  logic [29:0] b_addr_wr, b_addr_rd;
  logic [5:0]  b_cmd_bl;
  logic [2:0]  b_level;

  int          a_wr_n, a_rd_n, a_wr_cyc, a_rd_cyc, a_ord_n;
  int          b_wr_n, b_rd_n;
  logic [29:0] a_wr_addr, a_rd_addr, b_wr_addr, b_rd_addr;
  logic [7:0]  a_ord;

  lpddr_burst_sequencer u_dut_a (
    .clkA_addr(clk), .addr_rstA_wr(rst), .soft_clr(a_clr),
    .wr_req(a_wr_req), .rd_req(a_rd_req),
    .cmd_full_wr(a_full_wr), .cmd_full_rd(a_full_rd),
    .cmd_en_wr(a_en_wr), .cmd_en_rd(a_en_rd),
    .cmd_addr_wr(a_addr_wr), .cmd_addr_rd(a_addr_rd),
    .cmd_bl(a_cmd_bl), .level(a_level),
    .buf_full(a_buf_full), .buf_empty(a_buf_empty), .busy(a_busy),
    .ovr_err(a_ovr), .udr_err(a_udr)
  );

  lpddr_burst_sequencer #(.NSLOT(4)) u_dut_b (
    .clkA_addr(clk), .addr_rstA_wr(rst), .soft_clr(b_clr),
    .wr_req(b_wr_req), .rd_req(b_rd_req),
    .cmd_full_wr(b_full_wr), .cmd_full_rd(b_full_rd),
    .cmd_en_wr(b_en_wr), .cmd_en_rd(b_en_rd),
    .cmd_addr_wr(b_addr_wr), .cmd_addr_rd(b_addr_rd),
    .cmd_bl(b_cmd_bl), .level(b_level),
    .buf_full(b_buf_full), .buf_empty(b_buf_empty), .busy(b_busy),
    .ovr_err(b_ovr), .udr_err(b_udr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_en_wr) begin
      a_wr_n++; a_wr_addr = a_addr_wr; a_wr_cyc = cyc;
      a_ord = {a_ord[6:0], 1'b0}; a_ord_n++;
    end
    if (a_en_rd) begin
      a_rd_n++; a_rd_addr = a_addr_rd; a_rd_cyc = cyc;
      a_ord = {a_ord[6:0], 1'b1}; a_ord_n++;
    end
    if (b_en_wr) begin b_wr_n++; b_wr_addr = b_addr_wr; end
    if (b_en_rd) begin b_rd_n++; b_rd_addr = b_addr_rd; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input logic sel_b);
    for (int i = 0; i < 50; i++) begin
      if (!(sel_b ? b_busy : a_busy)) break;
      tick(1);
    end
    check(sel_b ? "b_idle_bound" : "a_idle_bound", sel_b ? b_busy : a_busy, 0);
  endtask

  task automatic a_wr;  a_wr_req = 1'b1; tick(1); a_wr_req = 1'b0; endtask
  task automatic a_rd;  a_rd_req = 1'b1; tick(1); a_rd_req = 1'b0; endtask
  task automatic b_wr;  b_wr_req = 1'b1; tick(1); b_wr_req = 1'b0; endtask
  task automatic b_rd;  b_rd_req = 1'b1; tick(1); b_rd_req = 1'b0; endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int req_c;
    int base_n;
    int exp_addr [4];
    exp_addr = '{32, 160, 288, 416};
    cyc = 0; n_chk = 0; n_err = 0;
    a_wr_n = 0; a_rd_n = 0; a_wr_cyc = 0; a_rd_cyc = 0; a_ord_n = 0; a_ord = '0;
    b_wr_n = 0; b_rd_n = 0;
    a_wr_addr = '0; a_rd_addr = '0; b_wr_addr = '0; b_rd_addr = '0;
    a_clr = 0; a_wr_req = 0; a_rd_req = 0; a_full_wr = 0; a_full_rd = 0;
    b_clr = 0; b_wr_req = 0; b_rd_req = 0; b_full_wr = 0; b_full_rd = 0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);

    check("rst_level",   a_level, 0);
    check("rst_empty",   a_buf_empty, 1);
    check("rst_full",    a_buf_full, 0);
    check("rst_busy",    a_busy, 0);
    check("rst_addr_wr", a_addr_wr, 32);
    check("rst_addr_rd", a_addr_rd, 32);
    check("cmd_bl",      a_cmd_bl, 31);
    check("b_cmd_bl",    b_cmd_bl, 31);
    check("rst_ovr",     a_ovr, 0);
    check("rst_udr",     a_udr, 0);

    // Single write then single read on the default ring.
    req_c = cyc;
    a_wr();
    wait_idle(1'b0);
    check("wr_count",    a_wr_n, 1);
    check("wr_latency",  a_wr_cyc - req_c, 2);
    check("wr_addr",     a_wr_addr, 32);
    check("wr_level",    a_level, 1);
    check("wr_next",     a_addr_wr, 160);
    req_c = cyc;
    a_rd();
    wait_idle(1'b0);
    check("rd_count",    a_rd_n, 1);
    check("rd_latency",  a_rd_cyc - req_c, 2);
    check("rd_addr",     a_rd_addr, 32);
    check("rd_level",    a_level, 0);
    check("rd_empty",    a_buf_empty, 1);

    // Read on empty ring is rejected.
    a_rd();
    tick(4);
    check("udr_count",   a_rd_n, 1);
    check("udr_flag",    a_udr, ERR_EN);
    check("udr_busy",    a_busy, 0);
    a_clr = 1'b1; tick(1); a_clr = 1'b0; tick(1);
    check("clr_udr",     a_udr, 0);
    check("clr_addr_wr", a_addr_wr, 32);
    check("clr_addr_rd", a_addr_rd, 32);

    // Command FIFO full stalls the write strobe.
    base_n = a_wr_n;
    a_full_wr = 1'b1;
    a_wr();
    tick(10);
    check("stall_none",  a_wr_n - base_n, 0);
    check("stall_busy",  a_busy, 1);
    a_full_wr = 1'b0;
    wait_idle(1'b0);
    tick(3);
    check("stall_one",   a_wr_n - base_n, 1);
    check("stall_level", a_level, 1);

    // Reset while a read is held in ISSUE_RD.
    base_n = a_rd_n;
    a_full_rd = 1'b1;
    a_rd();
    tick(5);
    check("abort_busy",  a_busy, 1);
    check("abort_pre",   a_level, 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    a_full_rd = 1'b0;
    tick(5);
    check("abort_none",  a_rd_n - base_n, 0);
    check("abort_level", a_level, 0);
    check("abort_addr",  a_addr_rd, 32);
    check("abort_idle",  a_busy, 0);

    // Contention order: W,R then R,W.
    a_wr(); wait_idle(1'b0);
    a_wr(); wait_idle(1'b0);
    check("pair_pre",    a_level, 2);
    a_ord = '0; a_ord_n = 0;
    a_wr_req = 1'b1; a_rd_req = 1'b1; tick(1); a_wr_req = 1'b0; a_rd_req = 1'b0;
    wait_idle(1'b0);
    check("pair1_n",     a_ord_n, 2);
    check("pair1_ord",   a_ord[1:0], 2'b01);
    check("pair1_level", a_level, 2);
    a_ord = '0; a_ord_n = 0;
    a_wr_req = 1'b1; a_rd_req = 1'b1; tick(1); a_wr_req = 1'b0; a_rd_req = 1'b0;
    wait_idle(1'b0);
    check("pair2_n",     a_ord_n, 2);
    check("pair2_ord",   a_ord[1:0], 2'b10);
    check("pair2_level", a_level, 2);

    // Small ring: fill to full, then overrun.
    for (int i = 0; i < 4; i++) begin
      b_wr(); wait_idle(1'b1);
      check("fill_addr",  b_wr_addr, exp_addr[i]);
    end
    check("fill_full",   b_buf_full, 1);
    check("fill_level",  b_level, 4);
    b_wr();
    tick(4);
    check("ovr_count",   b_wr_n, 4);
    check("ovr_flag",    b_ovr, ERR_EN);
    check("ovr_level",   b_level, 4);
    b_clr = 1'b1; tick(1); b_clr = 1'b0; tick(1);
    check("bclr_level",  b_level, 0);
    check("bclr_ovr",    b_ovr, 0);
    check("bclr_addr",   b_addr_wr, 32);

    // Small ring: five write/read pairs wrap the slot index.
    for (int i = 0; i < 5; i++) begin
      b_wr(); wait_idle(1'b1);
      check("wrap_wr",    b_wr_addr, exp_addr[i % 4]);
      b_rd(); wait_idle(1'b1);
      check("wrap_rd",    b_rd_addr, exp_addr[i % 4]);
    end
    check("wrap_level",  b_level, 0);
    check("wrap_empty",  b_buf_empty, 1);
    check("wrap_rd_n",   b_rd_n, 5);
    check("wrap_udr",    b_udr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
